// File: rtl/acq_sequencer_pkg.sv
// Shared definitions for the acquisition sequencer and its sample buffer.
// Record length and ADC width match the sampling controller.
package acq_sequencer_pkg;

  localparam int DATA_NUM = 405;
  localparam int ADC_W    = 8;
  localparam int CNT_W    = 10;
  localparam int TMR_W    = 22;

  localparam logic [1:0] RATE_AT_RESET = 2'b10;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_REQ,
    ST_WAIT_ACK,
    ST_CAPTURE,
    ST_DRAIN
  } acq_state_t;

endpackage

// File: rtl/acq_sequencer_if.sv
// Valid/ready stream carrying one captured record from the sequencer to the sender.
interface acq_sequencer_if
  import acq_sequencer_pkg::*;
#(
  parameter int DW = ADC_W
) ();

  logic [DW-1:0] data;
  logic          valid;
  logic          ready;
  logic          last;

  modport master (output data, output valid, output last, input ready);
  modport slave  (input data, input valid, input last, output ready);

endinterface

// File: rtl/acq_sample_buf.sv
// Simple dual-port record buffer: synchronous write, registered read with one cycle latency.
module acq_sample_buf
  import acq_sequencer_pkg::*;
#(
  parameter  int DEPTH = DATA_NUM,
  parameter  int W     = ADC_W,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic          in_clk,
  input  logic          wr_en,
  input  logic [AW-1:0] wr_addr,
  input  logic [W-1:0]  wr_data,
  input  logic          rd_en,
  input  logic [AW-1:0] rd_addr,
  output logic [W-1:0]  rd_data
);

  logic [W-1:0] mem [DEPTH];

  always_ff @(posedge in_clk) begin
    if (wr_en) mem[wr_addr] <= wr_data;
  end

  // Read data only changes on rd_en, so an unconsumed word stays on rd_data.
  always_ff @(posedge in_clk) begin
    if (rd_en) rd_data <= mem[rd_addr];
  end

endmodule

// File: rtl/acq_sequencer.sv
// Host-facing acquisition controller: requests a sampling run, captures one ADC word
// per ADC clock rise and streams the record out over a valid/ready interface.
module acq_sequencer
  import acq_sequencer_pkg::*;
#(
  parameter int DATA_NUM_P  = DATA_NUM,
  parameter int ADC_W_P     = ADC_W,
  parameter int REQ_PULSE   = 4,
  parameter int ACK_TIMEOUT = 16,
  parameter int CAP_TIMEOUT = 2_000_000
) (
  input  logic               in_clk,
  input  logic               in_rst,
  input  logic               in_cmd_start,
  input  logic               in_cmd_abort,
  input  logic [1:0]         in_cmd_rate,
  output logic               out_request_n,
  output logic [1:0]         out_sample_rate_select,
  input  logic               in_measure_sig,
  input  logic               in_adc_clk,
  input  logic [ADC_W_P-1:0] in_adc_data,
  acq_sequencer_if.master    stream,
  output logic               out_busy,
  output logic               out_timeout,
  output logic [CNT_W-1:0]   out_count
);

  localparam int AW = $clog2(DATA_NUM_P);
  localparam logic [CNT_W-1:0] DEPTH_C  = CNT_W'(DATA_NUM_P);
  localparam logic [TMR_W-1:0] REQ_LAST = TMR_W'(REQ_PULSE - 1);
  localparam logic [TMR_W-1:0] ACK_LAST = TMR_W'(ACK_TIMEOUT - 1);
  localparam logic [TMR_W-1:0] CAP_LAST = TMR_W'(CAP_TIMEOUT - 1);

  acq_state_t         state;
  logic [TMR_W-1:0]   tmr;
  logic [CNT_W-1:0]   wr_ptr;
  logic [CNT_W-1:0]   rd_ptr;
  logic [CNT_W-1:0]   ld_ptr;
  logic               rd_pend;
  logic               adc_clk_d;
  logic [ADC_W_P-1:0] adc_data_q;
  logic [ADC_W_P-1:0] rd_data;
  logic               adc_rise;
  logic               wr_en;
  logic               rd_en;
  logic               load;
  logic [CNT_W-1:0]   cap_total;

  always_ff @(posedge in_clk or negedge in_rst) begin
    if (!in_rst) begin
      adc_clk_d  <= 1'b0;
      adc_data_q <= '0;
    end else begin
      adc_clk_d  <= in_adc_clk;
      adc_data_q <= in_adc_data;
    end
  end

  assign adc_rise  = in_adc_clk && !adc_clk_d;
  assign wr_en     = (state == ST_CAPTURE) && adc_rise && (wr_ptr < DEPTH_C);
  assign cap_total = wr_ptr + CNT_W'(wr_en);

  // rd_pend marks a fetched word waiting in the buffer's read register; a new fetch
  // is issued only when that word moves into the output register this cycle.
  assign load  = (state == ST_DRAIN) && rd_pend && (!stream.valid || stream.ready);
  assign rd_en = (state == ST_DRAIN) && (rd_ptr < out_count) && (!rd_pend || load);

  acq_sample_buf #(
    .DEPTH (DATA_NUM_P),
    .W     (ADC_W_P)
  ) u_buf (
    .in_clk  (in_clk),
    .wr_en   (wr_en),
    .wr_addr (wr_ptr[AW-1:0]),
    .wr_data (adc_data_q),
    .rd_en   (rd_en),
    .rd_addr (rd_ptr[AW-1:0]),
    .rd_data (rd_data)
  );

  always_ff @(posedge in_clk or negedge in_rst) begin
    if (!in_rst) begin
      state                  <= ST_IDLE;
      tmr                    <= '0;
      wr_ptr                 <= '0;
      rd_ptr                 <= '0;
      ld_ptr                 <= '0;
      rd_pend                <= 1'b0;
      out_request_n          <= 1'b1;
      out_sample_rate_select <= RATE_AT_RESET;
      out_busy               <= 1'b0;
      out_timeout            <= 1'b0;
      out_count              <= '0;
      stream.data            <= '0;
      stream.valid           <= 1'b0;
      stream.last            <= 1'b0;
    end else if (in_cmd_abort && (state != ST_IDLE)) begin
      state         <= ST_IDLE;
      rd_pend       <= 1'b0;
      out_request_n <= 1'b1;
      out_busy      <= 1'b0;
      stream.valid  <= 1'b0;
      stream.last   <= 1'b0;
    end else begin
      unique case (state)
        ST_IDLE: begin
          if (in_cmd_start && !in_cmd_abort) begin
            state                  <= ST_REQ;
            tmr                    <= '0;
            out_sample_rate_select <= in_cmd_rate;
            out_timeout            <= 1'b0;
            out_count              <= '0;
            out_request_n          <= 1'b0;
            out_busy               <= 1'b1;
          end
        end
        ST_REQ: begin
          if (tmr == REQ_LAST) begin
            state         <= ST_WAIT_ACK;
            tmr           <= '0;
            out_request_n <= 1'b1;
          end else begin
            tmr <= tmr + 1'b1;
          end
        end
        ST_WAIT_ACK: begin
          if (in_measure_sig) begin
            state  <= ST_CAPTURE;
            tmr    <= '0;
            wr_ptr <= '0;
          end else if (tmr == ACK_LAST) begin
            state       <= ST_IDLE;
            out_timeout <= 1'b1;
            out_busy    <= 1'b0;
          end else begin
            tmr <= tmr + 1'b1;
          end
        end
        ST_CAPTURE: begin
          if (wr_en) wr_ptr <= wr_ptr + 1'b1;
          // An empty record has nothing to stream, even after a capture timeout.
          if (!in_measure_sig || (tmr == CAP_LAST)) begin
            if (in_measure_sig) out_timeout <= 1'b1;
            out_count <= cap_total;
            rd_ptr    <= '0;
            ld_ptr    <= '0;
            rd_pend   <= 1'b0;
            if (cap_total == '0) begin
              state    <= ST_IDLE;
              out_busy <= 1'b0;
            end else begin
              state <= ST_DRAIN;
            end
          end else begin
            tmr <= tmr + 1'b1;
          end
        end
        ST_DRAIN: begin
          if (rd_en) begin
            rd_ptr  <= rd_ptr + 1'b1;
            rd_pend <= 1'b1;
          end else if (load) begin
            rd_pend <= 1'b0;
          end
          if (load) begin
            stream.data  <= rd_data;
            stream.valid <= 1'b1;
            stream.last  <= (ld_ptr == out_count - CNT_W'(1));
            ld_ptr       <= ld_ptr + 1'b1;
          end else if (stream.valid && stream.ready) begin
            stream.valid <= 1'b0;
            stream.last  <= 1'b0;
            if (stream.last) begin
              state    <= ST_IDLE;
              out_busy <= 1'b0;
            end
          end
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_acq_sequencer.sv
// Directed bench for acq_sequencer: sampler/ADC model, stream sink with ready patterns,
// timeout, overflow, abort and rate-lock scenarios with hand-computed expectations.
module tb_acq_sequencer;
  import acq_sequencer_pkg::*;

  logic       in_clk = 1'b0;
  logic       in_rst = 1'b0;
  logic       in_cmd_start = 1'b0;
  logic       in_cmd_abort = 1'b0;
  logic [1:0] in_cmd_rate = 2'b00;
  logic       out_request_n;
  logic [1:0] out_sample_rate_select;
  logic       in_measure_sig = 1'b0;
  logic       in_adc_clk = 1'b0;
  logic [7:0] in_adc_data = 8'h00;
  logic       out_busy;
  logic       out_timeout;
  logic [9:0] out_count;

  int n_checks = 0;
  int n_pass   = 0;

  int         d_words, d_bad, d_bad_idx, d_last_n, d_last_idx, d_unstable, d_first;
  logic [7:0] d_bad_val;
  bit         d_done;

  acq_sequencer_if #(.DW(8)) sif ();

  acq_sequencer dut (
    .in_clk                 (in_clk),
    .in_rst                 (in_rst),
    .in_cmd_start           (in_cmd_start),
    .in_cmd_abort           (in_cmd_abort),
    .in_cmd_rate            (in_cmd_rate),
    .out_request_n          (out_request_n),
    .out_sample_rate_select (out_sample_rate_select),
    .in_measure_sig         (in_measure_sig),
    .in_adc_clk             (in_adc_clk),
    .in_adc_data            (in_adc_data),
    .stream                 (sif),
    .out_busy               (out_busy),
    .out_timeout            (out_timeout),
    .out_count              (out_count)
  );

  always #5 in_clk = ~in_clk;

  task automatic tick();
    @(posedge in_clk);
    #1;
  endtask

  task automatic start_acq(input logic [1:0] rate);
    in_cmd_rate  = rate;
    in_cmd_start = 1'b1;
    tick();
    in_cmd_start = 1'b0;
  endtask

  task automatic wait_request(output int low);
    low = 0;
    while (out_request_n === 1'b0 && low < 50) begin
      low++;
      tick();
    end
  endtask

  task automatic sampler_begin();
    repeat (3) tick();
    in_measure_sig = 1'b1;
  endtask

  // Data is set while the ADC clock is low and held through its high cycle.
  task automatic adc_rises(input int base, input int n);
    for (int i = 0; i < n; i++) begin
      in_adc_data = 8'(base + i);
      tick();
      in_adc_clk = 1'b1;
      tick();
      in_adc_clk = 1'b0;
    end
  endtask

  task automatic sampler_end();
    in_measure_sig = 1'b0;
    tick();
  endtask

  task automatic drain(input bit toggle, input int abort_after);
    logic [7:0] held_data;
    logic       held_last;
    bit         stalled;
    d_words = 0; d_bad = 0; d_bad_idx = -1; d_bad_val = 8'h00; d_last_n = 0;
    d_last_idx = -1; d_unstable = 0; d_first = -1; d_done = 1'b0; stalled = 1'b0;
    held_data = 8'h00; held_last = 1'b0;
    for (int cyc = 0; cyc < 3000 && !d_done; cyc++) begin
      if (abort_after >= 0 && d_words == abort_after) begin
        sif.ready    = 1'b0;
        in_cmd_abort = 1'b1;
        tick();
        in_cmd_abort = 1'b0;
        d_done       = 1'b1;
      end else begin
        sif.ready = toggle ? ((cyc % 4 == 0) || (cyc % 4 == 3)) : 1'b1;
        if (sif.valid === 1'b1 && d_first < 0) d_first = cyc;
        if (stalled && (sif.valid !== 1'b1 || sif.data !== held_data || sif.last !== held_last))
          d_unstable++;
        if (sif.valid === 1'b1 && sif.ready === 1'b1) begin
          if (sif.data !== 8'(d_words)) begin
            if (d_bad == 0) begin
              d_bad_idx = d_words;
              d_bad_val = sif.data;
            end
            d_bad++;
          end
          if (sif.last === 1'b1) begin
            d_last_n++;
            d_last_idx = d_words;
            d_done     = 1'b1;
          end
          d_words++;
        end
        stalled   = (sif.valid === 1'b1) && (sif.ready !== 1'b1);
        held_data = sif.data;
        held_last = sif.last;
        tick();
      end
    end
    sif.ready = 1'b0;
  endtask

  task automatic test_reset();
    in_rst = 1'b0;
    tick();
    tick();
    n_checks++;
    if (out_request_n !== 1'b1) $display("[TB] FAIL reset_request_n: got %b expected 1", out_request_n);
    else n_pass++;
    n_checks++;
    if ({sif.valid, sif.last, out_busy, out_timeout} !== 4'b0000)
      $display("[TB] FAIL reset_flags: got valid/last/busy/timeout=%b expected 0000",
               {sif.valid, sif.last, out_busy, out_timeout});
    else n_pass++;
    n_checks++;
    if (out_count !== 10'd0 || sif.data !== 8'h00)
      $display("[TB] FAIL reset_count_data: got count=%0d data=%0d expected 0/0", out_count, sif.data);
    else n_pass++;
    n_checks++;
    if (out_sample_rate_select !== 2'b10)
      $display("[TB] FAIL reset_rate: got %b expected 10", out_sample_rate_select);
    else n_pass++;
    in_rst = 1'b1;
    tick();
  endtask

  task automatic test_full_record();
    int low;
    start_acq(2'b01);
    wait_request(low);
    n_checks++;
    if (low !== 4) $display("[TB] FAIL full_req_len: got %0d cycles expected 4", low);
    else n_pass++;
    sampler_begin();
    adc_rises(0, 405);
    sampler_end();
    n_checks++;
    if (out_count !== 10'd405) $display("[TB] FAIL full_count: got %0d expected 405", out_count);
    else n_pass++;
    n_checks++;
    if (out_sample_rate_select !== 2'b01)
      $display("[TB] FAIL full_rate: got %b expected 01", out_sample_rate_select);
    else n_pass++;
    drain(1'b0, -1);
    n_checks++;
    if (d_first !== 2) $display("[TB] FAIL full_first_valid: got cycle %0d expected 2", d_first);
    else n_pass++;
    n_checks++;
    if (d_words !== 405) $display("[TB] FAIL full_words: got %0d expected 405", d_words);
    else n_pass++;
    n_checks++;
    if (d_bad !== 0)
      $display("[TB] FAIL full_data: word %0d got %0d expected %0d (%0d bad)",
               d_bad_idx, d_bad_val, d_bad_idx % 256, d_bad);
    else n_pass++;
    n_checks++;
    if (d_last_n !== 1 || d_last_idx !== 404)
      $display("[TB] FAIL full_last: got %0d lasts at word %0d expected 1 at 404", d_last_n, d_last_idx);
    else n_pass++;
    n_checks++;
    if (sif.valid !== 1'b0 || out_busy !== 1'b0)
      $display("[TB] FAIL full_end_idle: got valid=%b busy=%b expected 0/0", sif.valid, out_busy);
    else n_pass++;
  endtask

  task automatic test_stall();
    int low;
    start_acq(2'b01);
    wait_request(low);
    sampler_begin();
    adc_rises(0, 405);
    sampler_end();
    drain(1'b1, -1);
    n_checks++;
    if (d_words !== 405 || d_done !== 1'b1)
      $display("[TB] FAIL stall_words: got %0d done=%b expected 405 done=1", d_words, d_done);
    else n_pass++;
    n_checks++;
    if (d_bad !== 0)
      $display("[TB] FAIL stall_data: word %0d got %0d expected %0d", d_bad_idx, d_bad_val, d_bad_idx % 256);
    else n_pass++;
    n_checks++;
    if (d_unstable !== 0) $display("[TB] FAIL stall_hold: got %0d unstable cycles expected 0", d_unstable);
    else n_pass++;
    n_checks++;
    if (d_last_n !== 1 || d_last_idx !== 404)
      $display("[TB] FAIL stall_last: got %0d lasts at word %0d expected 1 at 404", d_last_n, d_last_idx);
    else n_pass++;
  endtask

  task automatic test_overflow();
    int low;
    start_acq(2'b10);
    wait_request(low);
    sampler_begin();
    adc_rises(0, 410);
    sampler_end();
    n_checks++;
    if (out_count !== 10'd405) $display("[TB] FAIL ovf_count: got %0d expected 405", out_count);
    else n_pass++;
    drain(1'b0, -1);
    n_checks++;
    if (d_words !== 405 || d_bad !== 0 || d_last_idx !== 404)
      $display("[TB] FAIL ovf_record: got words=%0d bad=%0d last_at=%0d expected 405/0/404",
               d_words, d_bad, d_last_idx);
    else n_pass++;
  endtask

  task automatic test_timeout();
    int low;
    int n;
    bit saw_valid;
    start_acq(2'b00);
    wait_request(low);
    n = 0;
    saw_valid = 1'b0;
    while (out_timeout !== 1'b1 && n < 40) begin
      if (sif.valid === 1'b1) saw_valid = 1'b1;
      tick();
      n++;
    end
    n_checks++;
    if (n !== 16) $display("[TB] FAIL timeout_cycles: got %0d expected 16", n);
    else n_pass++;
    n_checks++;
    if (out_busy !== 1'b0) $display("[TB] FAIL timeout_idle: got busy=%b expected 0", out_busy);
    else n_pass++;
    n_checks++;
    if (saw_valid !== 1'b0) $display("[TB] FAIL timeout_no_valid: got %b expected 0", saw_valid);
    else n_pass++;
  endtask

  task automatic test_abort_start_same_cycle();
    in_cmd_rate  = 2'b11;
    in_cmd_start = 1'b1;
    in_cmd_abort = 1'b1;
    tick();
    in_cmd_start = 1'b0;
    in_cmd_abort = 1'b0;
    tick();
    n_checks++;
    if (out_busy !== 1'b0 || out_request_n !== 1'b1)
      $display("[TB] FAIL abort_wins: got busy=%b request_n=%b expected 0/1", out_busy, out_request_n);
    else n_pass++;
    n_checks++;
    if (out_timeout !== 1'b1 || out_sample_rate_select !== 2'b00)
      $display("[TB] FAIL abort_wins_state: got timeout=%b rate=%b expected 1/00",
               out_timeout, out_sample_rate_select);
    else n_pass++;
  endtask

  task automatic test_abort_drain();
    int low;
    start_acq(2'b01);
    n_checks++;
    if (out_timeout !== 1'b0) $display("[TB] FAIL restart_clears_timeout: got %b expected 0", out_timeout);
    else n_pass++;
    wait_request(low);
    sampler_begin();
    adc_rises(0, 405);
    sampler_end();
    drain(1'b0, 100);
    n_checks++;
    if (d_words !== 100) $display("[TB] FAIL abort_words: got %0d expected 100", d_words);
    else n_pass++;
    n_checks++;
    if (sif.valid !== 1'b0 || out_busy !== 1'b0)
      $display("[TB] FAIL abort_idle: got valid=%b busy=%b expected 0/0", sif.valid, out_busy);
    else n_pass++;
    tick();
    start_acq(2'b01);
    wait_request(low);
    sampler_begin();
    adc_rises(0, 405);
    sampler_end();
    drain(1'b0, -1);
    n_checks++;
    if (d_words !== 405 || d_bad !== 0 || d_last_idx !== 404)
      $display("[TB] FAIL abort_rerun: got words=%0d bad=%0d last_at=%0d expected 405/0/404",
               d_words, d_bad, d_last_idx);
    else n_pass++;
  endtask

  task automatic test_rate_lock();
    int low;
    start_acq(2'b11);
    wait_request(low);
    sampler_begin();
    adc_rises(0, 3);
    in_cmd_rate  = 2'b00;
    in_cmd_start = 1'b1;
    tick();
    in_cmd_start = 1'b0;
    n_checks++;
    if (out_sample_rate_select !== 2'b11)
      $display("[TB] FAIL rate_lock: got %b expected 11", out_sample_rate_select);
    else n_pass++;
    n_checks++;
    if (out_request_n !== 1'b1 || out_busy !== 1'b1)
      $display("[TB] FAIL rate_lock_state: got request_n=%b busy=%b expected 1/1", out_request_n, out_busy);
    else n_pass++;
    adc_rises(3, 2);
    sampler_end();
    n_checks++;
    if (out_count !== 10'd5) $display("[TB] FAIL rate_lock_count: got %0d expected 5", out_count);
    else n_pass++;
    drain(1'b0, -1);
    n_checks++;
    if (d_words !== 5 || d_bad !== 0 || d_last_idx !== 4)
      $display("[TB] FAIL rate_lock_record: got words=%0d bad=%0d last_at=%0d expected 5/0/4",
               d_words, d_bad, d_last_idx);
    else n_pass++;
  endtask

  initial begin
    sif.ready = 1'b0;
    test_reset();
    test_full_record();
    test_stall();
    test_overflow();
    test_timeout();
    test_abort_start_same_cycle();
    test_abort_drain();
    test_rate_lock();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
